// File: rtl/pool_tile_sequencer.sv
// Quadrant-pooling tile sequencer.
// Accepts four input tiles, presents each to an external pooling datapath
// together with a quadrant select, and collects the selected quadrant of
// each pooled result into an accumulator. The assembled frame is then
// offered downstream on a valid/ready handshake.
module pool_tile_sequencer #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = WIDTH_IN / 2,
  parameter int PIX_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixels   [WIDTH_IN*WIDTH_IN],
  output logic [PIX_W-1:0] pool_pixels [WIDTH_IN*WIDTH_IN],
  output logic [1:0]       pool_sub_block,
  input  logic [PIX_W-1:0] pool_result [WIDTH_IN*WIDTH_IN],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixels  [WIDTH_IN*WIDTH_IN],
  output logic [1:0]       quad
);

  localparam int NPIX = WIDTH_IN * WIDTH_IN;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    POOL   = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t           state;
  logic [PIX_W-1:0] acc [NPIX];
  logic [NPIX-1:0]  in_quad;

  // Each pixel's quadrant number is fixed by its position, so the
  // "belongs to the current quadrant" test reduces to a 2-bit compare.
  for (genvar g = 0; g < NPIX; g++) begin : g_region
    localparam int         ROW = g / WIDTH_IN;
    localparam int         COL = g % WIDTH_IN;
    localparam logic [1:0] QID = 2'((ROW / WIDTH_OUT) * 2 + (COL / WIDTH_OUT));
    assign in_quad[g] = (quad == QID);
  end

  assign out_pixels     = acc;
  assign pool_sub_block = quad;

  // Sequencer FSM with registered handshake outputs, tile capture and
  // quadrant-masked accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCEPT;
      quad        <= 2'd0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      // NOTE: the tile and accumulator arrays are genuinely reset here
      // because downstream logic observes them straight after reset; a
      // plain data buffer that is never read before being written would
      // normally be left without reset.
      pool_pixels <= '{default: '0};
      acc         <= '{default: '0};
    end else if (abort) begin
      // Discard the partial frame; any handshake this cycle is ignored.
      state     <= ACCEPT;
      quad      <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc       <= '{default: '0};
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid && in_ready) begin
            // NOTE: every assignment in this clocked block is non-blocking,
            // so all registers update together from pre-edge values.
            pool_pixels <= in_pixels;
            in_ready    <= 1'b0;
            state       <= POOL;
          end
        end
        POOL: begin
          for (int i = 0; i < NPIX; i++) begin
            if (in_quad[i]) acc[i] <= pool_result[i];
          end
          if (quad == 2'd3) begin
            out_valid <= 1'b1;
            state     <= EMIT;
          end else begin
            quad     <= quad + 2'd1;
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            acc       <= '{default: '0};
            quad      <= 2'd0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCEPT;
          end
        end
        default: begin
          state     <= ACCEPT;
          quad      <= 2'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_tile_sequencer.sv
// Directed testbench for pool_tile_sequencer. The pooling datapath is
// modelled as a pass-through of pool_pixels, so every pool_result pixel is
// nonzero and only the selected quadrant may reach the accumulator.
module tb_pool_tile_sequencer;

  localparam int W_IN  = 8;
  localparam int W_OUT = 4;
  localparam int PW    = 32;
  localparam int NPIX  = W_IN * W_IN;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pixels   [NPIX];
  logic [PW-1:0] pool_pixels [NPIX];
  logic [1:0]    pool_sub_block;
  logic [PW-1:0] pool_result [NPIX];
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pixels  [NPIX];
  logic [1:0]    quad;

  logic [PW-1:0] exp_frame [NPIX];
  int            errors = 0;
  int            checks = 0;

  pool_tile_sequencer #(.WIDTH_IN(W_IN), .WIDTH_OUT(W_OUT), .PIX_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .abort          (abort),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pixels      (in_pixels),
    .pool_pixels    (pool_pixels),
    .pool_sub_block (pool_sub_block),
    .pool_result    (pool_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pixels     (out_pixels),
    .quad           (quad)
  );

  always #5 clk = ~clk;

  // Pass-through pooling datapath model.
  always_comb begin
    for (int i = 0; i < NPIX; i++) pool_result[i] = pool_pixels[i];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int qid(input int i);
    return ((i / W_IN) / W_OUT) * 2 + ((i % W_IN) / W_OUT);
  endfunction

  // Expected frame: quadrant q holds tile value b[q] + step*index.
  task automatic build_expect(input int b0, input int b1, input int b2,
                              input int b3, input int step);
    int b;
    for (int i = 0; i < NPIX; i++) begin
      case (qid(i))
        0:       b = b0;
        1:       b = b1;
        2:       b = b2;
        default: b = b3;
      endcase
      exp_frame[i] = PW'(b + step * i);
    end
  endtask

  // Present a tile, wait (bounded) for acceptance, optionally spend the POOL cycle.
  task automatic send_tile(input int base, input int step, input bit do_pool);
    int n = 0;
    for (int i = 0; i < NPIX; i++) in_pixels[i] = PW'(base + step * i);
    in_valid = 1'b1;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_tile_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
    if (do_pool) tick();
  endtask

  task automatic test_reset;
    int nz = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, quad, pool_sub_block} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/quad/sub=%b required 100000",
               {in_ready, out_valid, quad, pool_sub_block});
    end
    for (int i = 0; i < NPIX; i++) if (out_pixels[i] !== '0 || pool_pixels[i] !== '0) nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL reset_data: %0d nonzero pixels, required 0", nz);
    end
  endtask

  task automatic test_basic_frame;
    int mism = 0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (quad !== 2'(k - 1)) begin
        errors++;
        $display("FAIL basic_quad_before: got %0d required %0d", quad, k - 1);
      end
      send_tile(4 * k, 0, 1'b0);
      checks++;
      if (pool_pixels[NPIX-1] !== PW'(4 * k) || pool_sub_block !== 2'(k - 1) ||
          in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_pool_phase: pix=%0d sub=%0d ready=%0b valid=%0b required %0d %0d 0 0",
                 pool_pixels[NPIX-1], pool_sub_block, in_ready, out_valid, 4 * k, k - 1);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%0b two cycles after 4th accept, required 1", out_valid);
    end
    build_expect(4, 8, 12, 16, 0);
    for (int i = 0; i < NPIX; i++) if (out_pixels[i] !== exp_frame[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL basic_frame: %0d pixels wrong, pixel0=%0d required %0d",
               mism, out_pixels[0], exp_frame[0]);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quad !== 2'd0 || out_pixels[NPIX-1] !== '0) begin
      errors++;
      $display("FAIL basic_after_emit: valid=%0b ready=%0b quad=%0d pix=%0d required 0 1 0 0",
               out_valid, in_ready, quad, out_pixels[NPIX-1]);
    end
  endtask

  task automatic test_backpressure;
    int mism;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_tile(256 * k, 1, 1'b1);
    build_expect(256, 512, 768, 1024, 1);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mism = 0;
      for (int i = 0; i < NPIX; i++) if (out_pixels[i] !== exp_frame[i]) mism++;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || mism != 0) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%0b ready=%0b wrong_pixels=%0d required 1 0 0",
                 c, out_valid, in_ready, mism);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quad !== 2'd0) begin
      errors++;
      $display("FAIL stall_release: valid=%0b ready=%0b quad=%0d required 0 1 0",
               out_valid, in_ready, quad);
    end
  endtask

  task automatic test_back_to_back;
    int accepts = 0;
    int mism = 0;
    out_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) in_pixels[i] = 32'd7;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (in_ready !== ((c % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_ready_cycle%0d: got %0b required %0b", c, in_ready, (c % 2) == 0);
      end
      if (in_ready) begin
        checks++;
        if (quad !== 2'(accepts)) begin
          errors++;
          $display("FAIL b2b_quad: got %0d required %0d", quad, accepts);
        end
        accepts++;
      end
      tick();
    end
    for (int i = 0; i < NPIX; i++) if (out_pixels[i] !== 32'd7) mism++;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || accepts != 4 || mism != 0) begin
      errors++;
      $display("FAIL b2b_frame: valid=%0b ready=%0b accepts=%0d wrong_pixels=%0d required 1 0 4 0",
               out_valid, in_ready, accepts, mism);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    int mism = 0;
    out_ready = 1'b1;
    send_tile(32'h55, 0, 1'b1);
    send_tile(32'h55, 0, 1'b1);
    send_tile(32'h55, 0, 1'b0);
    checks++;
    if (quad !== 2'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_setup: quad=%0d ready=%0b required 2 0", quad, in_ready);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || quad !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_pool: ready=%0b quad=%0d valid=%0b required 1 0 0",
               in_ready, quad, out_valid);
    end
    // Abort must also swallow a handshake presented in the same cycle.
    for (int i = 0; i < NPIX; i++) in_pixels[i] = 32'hAA;
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || quad !== 2'd0 || pool_pixels[0] !== 32'h55) begin
      errors++;
      $display("FAIL abort_handshake: ready=%0b quad=%0d pool_pix=%0h required 1 0 55",
               in_ready, quad, pool_pixels[0]);
    end
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_tile(k, 0, 1'b1);
    build_expect(1, 2, 3, 4, 0);
    for (int i = 0; i < NPIX; i++) if (out_pixels[i] !== exp_frame[i]) mism++;
    checks++;
    if (out_valid !== 1'b1 || mism != 0) begin
      errors++;
      $display("FAIL abort_next_frame: valid=%0b wrong_pixels=%0d required 1 0", out_valid, mism);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_in_emit;
    int nz = 0;
    int mism = 0;
    out_ready = 1'b0;
    send_tile(100, 2, 1'b1);
    send_tile(200, 2, 1'b1);
    send_tile(300, 2, 1'b1);
    send_tile(400, 2, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_emit_setup: out_valid=%0b required 1", out_valid);
    end
    reset     = 1'b1;
    abort     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) if (out_pixels[i] !== '0 || pool_pixels[i] !== '0) nz++;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quad !== 2'd0 || nz != 0) begin
      errors++;
      $display("FAIL rst_emit_state: ready=%0b valid=%0b quad=%0d nonzero=%0d required 1 0 0 0",
               in_ready, out_valid, quad, nz);
    end
    // First tile after reset lands in quadrant 0 only.
    send_tile(9, 0, 1'b1);
    build_expect(9, 0, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) if (out_pixels[i] !== exp_frame[i]) mism++;
    checks++;
    if (quad !== 2'd1 || mism != 0) begin
      errors++;
      $display("FAIL rst_first_tile: quad=%0d wrong_pixels=%0d required 1 0", quad, mism);
    end
    send_tile(10, 0, 1'b1);
    send_tile(11, 0, 1'b1);
    send_tile(12, 0, 1'b1);
    build_expect(9, 10, 11, 12, 0);
    mism = 0;
    for (int i = 0; i < NPIX; i++) if (out_pixels[i] !== exp_frame[i]) mism++;
    checks++;
    if (out_valid !== 1'b1 || mism != 0) begin
      errors++;
      $display("FAIL rst_followup_frame: valid=%0b wrong_pixels=%0d required 1 0", out_valid, mism);
    end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) in_pixels[i] = '0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_in_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool_tile_sequencer.md
POOL_TILE_SEQUENCER -- requirements
Module: pool_tile_sequencer

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 8, meaning input tile edge in pixels.
REQ-002 SHALL have parameter WIDTH_OUT, default 4, meaning pooled quadrant edge, fixed at WIDTH_IN/2.
REQ-003 SHALL have parameter PIX_W, default 32, meaning pixel width in bits.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 abort  input  1  synchronous discard of the partially assembled frame.
REQ-007 in_valid  input  1  an input tile is presented.
REQ-008 in_ready  output  1  the sequencer accepts a tile this cycle.
REQ-009 in_pixels  input  WIDTH_IN*WIDTH_IN x PIX_W  input tile, row-major, index = col + row*WIDTH_IN.
REQ-010 pool_pixels  output  WIDTH_IN*WIDTH_IN x PIX_W  registered tile driven to the pooling datapath.
REQ-011 pool_sub_block  output  2  quadrant select driven to the pooling datapath.
REQ-012 pool_result  input  WIDTH_IN*WIDTH_IN x PIX_W  combinational pooled result returned by the datapath.
REQ-013 out_valid  output  1  an assembled frame is presented.
REQ-014 out_ready  input  1  the downstream consumer accepts the frame.
REQ-015 out_pixels  output  WIDTH_IN*WIDTH_IN x PIX_W  assembled frame, row-major.
REQ-016 quad  output  2  index of the next quadrant to be filled.

Function
REQ-017 The FSM SHALL have exactly three states: ACCEPT, POOL and EMIT.
REQ-018 In ACCEPT: in_ready=1; on in_valid&&in_ready, register in_pixels into pool_pixels and go to POOL.
REQ-019 In POOL: in_ready=0; pool_sub_block=quad; at the end of the cycle, copy only quadrant region quad from pool_result into the accumulator.
REQ-020 Quadrant q region SHALL be rows (q>>1)*WIDTH_OUT to +WIDTH_OUT-1 and cols (q&1)*WIDTH_OUT to +WIDTH_OUT-1; all other accumulator pixels are held unchanged.
REQ-021 After POOL: if quad<3, then quad increments and the state returns to ACCEPT; if quad==3, the state goes to EMIT with quad held at 3.
REQ-022 In EMIT: out_valid=1, out_pixels=accumulator, in_ready=0; out_pixels SHALL stay stable while out_valid&&!out_ready.
REQ-023 On out_valid&&out_ready: clear the accumulator to 0, set quad=0, go to ACCEPT; the next tile can be accepted in the following cycle.
REQ-024 Throughput SHALL be one tile per 2 cycles; frame latency from the 4th tile handshake to out_valid is 2 cycles.
REQ-025 pool_sub_block SHALL equal quad in all states; pool_pixels changes only on an input handshake.
REQ-026 out_valid SHALL be 0 in ACCEPT and POOL.
REQ-027 abort (when reset=0) in any state SHALL force ACCEPT, quad=0 and accumulator=0, and SHALL suppress any same-cycle handshake or capture.
REQ-028 The sequencer SHALL perform no arithmetic on pixel data; widths pass through unchanged.

Reset
REQ-029 reset SHALL override abort and all handshakes.
REQ-030 After reset: state=ACCEPT, quad=0, accumulator=0, pool_pixels=0, out_valid=0, in_ready=1.
REQ-031 Reset mid-frame SHALL discard all captured quadrants; the first tile after reset fills quadrant 0.

Verification
REQ-032 Four tiles, all pixels = 4*k for tile k=1..4, out_ready=1, ideal pool model -> out_valid 2 cycles after the 4th accept; quadrants 0,1,2,3 = 4,8,12,16.
REQ-033 out_ready=0 for 5 cycles in EMIT -> out_valid held and out_pixels stable; in_ready=0 throughout; frame accepted on the cycle out_ready rises.
REQ-034 in_valid held high continuously -> in_ready toggles 1,0,1,0...; exactly 4 accepts per frame; quad sequence 0,1,2,3.
REQ-035 abort asserted in POOL with quad=2 -> next cycle ACCEPT, quad=0; the following frame shows no residue of the earlier quadrants.
REQ-036 reset and abort asserted together in EMIT -> all post-reset values of REQ-030 are met; no out handshake is counted.
REQ-037 pool_result nonzero outside the quad region -> accumulator pixels outside that quadrant remain unchanged.
